// File: rtl/msi_irq_scheduler.sv
// msi_irq_scheduler: latches per-source interrupt events and issues them round-robin as MSI requests with holdoff, retry and timeout.
module msi_irq_scheduler #(
  parameter int SRC_COUNT      = 8,
  parameter int HOLDOFF_CYCLES = 256,
  parameter int RETRY_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SRC_COUNT-1:0] IRQ_IN,
  input  logic [SRC_COUNT-1:0] SRC_ENABLE,
  output logic                 MSI_REQ,
  output logic [4:0]           MSI_VECTOR,
  input  logic                 MSI_GRANT,
  input  logic                 MSI_FAIL,
  output logic [SRC_COUNT-1:0] PENDING,
  output logic                 BUSY,
  output logic                 TIMEOUT_ERR
);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int RW = $clog2(RETRY_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, REQ, RETRY, GAP} state_t;
  state_t state, state_nx;
  logic [SRC_COUNT-1:0]   eligible, gsel;
  logic [2*SRC_COUNT-1:0] rot;
  logic [HW-1:0]          hold [SRC_COUNT];
  logic [4:0]             ptr, off, win;
  logic [5:0]             sum;
  logic [TW-1:0]          tcnt;
  logic [RW-1:0]          rcnt;
  logic                   found, grant, fail, tmo;
  // GRANT beats FAIL, and either beats the timeout in the same cycle
  assign grant = (state == REQ) && MSI_GRANT;
  assign fail  = (state == REQ) && !MSI_GRANT && MSI_FAIL;
  assign tmo   = (state == REQ) && !MSI_GRANT && !MSI_FAIL && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign gsel  = grant ? (SRC_COUNT'(1) << MSI_VECTOR) : '0;
  for (genvar i = 0; i < SRC_COUNT; i++) begin : g_src
    assign eligible[i] = PENDING[i] & SRC_ENABLE[i] & (hold[i] == '0);
    always_ff @(posedge clk) begin
      if (reset) begin
        PENDING[i] <= 1'b0;
        hold[i]    <= '0;
      end else begin
        PENDING[i] <= (PENDING[i] & ~gsel[i]) | (IRQ_IN[i] & SRC_ENABLE[i]);
        hold[i]    <= gsel[i] ? HW'(HOLDOFF_CYCLES) : (hold[i] != '0 ? hold[i] - HW'(1) : hold[i]);
      end
    end
  end
  // rotate so the search starts at ptr; lowest set bit of the rotated view wins
  always_comb begin
    rot = {eligible, eligible} >> ptr;
    off = '0;
    for (int k = SRC_COUNT - 1; k >= 0; k--)
      if (rot[k]) off = 5'(k);
    sum   = {1'b0, ptr} + {1'b0, off};
    win   = (sum >= 6'(SRC_COUNT)) ? 5'(sum - 6'(SRC_COUNT)) : sum[4:0];
    found = |eligible;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = found ? REQ : IDLE;
      REQ:     state_nx = grant ? GAP : ((fail || tmo) ? RETRY : REQ);
      RETRY:   state_nx = (rcnt <= RW'(1)) ? IDLE : RETRY;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    MSI_REQ = (state == REQ);
    BUSY    = (state != IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      MSI_VECTOR  <= '0;
      tcnt        <= '0;
      rcnt        <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      TIMEOUT_ERR <= tmo;
      tcnt        <= (state == REQ) ? tcnt + TW'(1) : '0;
      rcnt        <= (fail || tmo) ? RW'(RETRY_CYCLES) : ((state == RETRY) ? rcnt - RW'(1) : rcnt);
      if (state == IDLE && found) MSI_VECTOR <= win;
      if (grant) ptr <= (MSI_VECTOR == 5'(SRC_COUNT - 1)) ? '0 : MSI_VECTOR + 5'd1;
    end
  end
endmodule

// File: tb/tb_msi_irq_scheduler.sv
// tb_msi_irq_scheduler: scoreboard of expected MSI vectors plus per-scenario timing and state checks.
module tb_msi_irq_scheduler;
  localparam int N = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] irq_in = '0, src_enable = '1;
  logic msi_grant = 1'b0, msi_fail = 1'b0;
  logic msi_req, busy, timeout_err;
  logic [4:0] msi_vector;
  logic [N-1:0] pending;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [4:0] exp_q [$];

  msi_irq_scheduler #(.SRC_COUNT(N), .HOLDOFF_CYCLES(256), .RETRY_CYCLES(16), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .IRQ_IN(irq_in), .SRC_ENABLE(src_enable),
    .MSI_REQ(msi_req), .MSI_VECTOR(msi_vector), .MSI_GRANT(msi_grant), .MSI_FAIL(msi_fail),
    .PENDING(pending), .BUSY(busy), .TIMEOUT_ERR(timeout_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // pops the expected vector on every MSI_REQ rising edge and checks the vector holds while high
  task automatic monitor();
    logic prev_req = 1'b0;
    logic [4:0] prev_vec = '0, e;
    forever begin
      @(negedge clk);
      if (msi_req && !prev_req) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_req: got vector %0d expected no request", msi_vector);
        end else begin
          e = exp_q.pop_front();
          if (msi_vector !== e) begin
            n_bad++;
            $display("FAIL vector_order: got %0d expected %0d", msi_vector, e);
          end
        end
      end else if (msi_req && prev_req) begin
        n_cmp++;
        if (msi_vector !== prev_vec) begin
          n_bad++;
          $display("FAIL vector_stable: got %0d expected %0d", msi_vector, prev_vec);
        end
      end
      prev_req = msi_req;
      prev_vec = msi_vector;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; irq_in = '0; msi_grant = 1'b0; msi_fail = 1'b0; src_enable = '1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic pulse_irq(input logic [N-1:0] m);
    irq_in = m;
    tick();
    irq_in = '0;
  endtask

  task automatic grant_now();
    msi_grant = 1'b1;
    tick();
    msi_grant = 1'b0;
  endtask

  task automatic wait_req(input int bound, output int n);
    n = 0;
    while (!msi_req && n < bound) begin
      tick();
      n++;
    end
    if (!msi_req) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_req: got no request after %0d cycles expected MSI_REQ=1", n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (msi_req !== 1'b0)    begin n_bad++; $display("FAIL rst_req: got %b expected 0", msi_req); end
    n_cmp++; if (msi_vector !== 5'd0) begin n_bad++; $display("FAIL rst_vec: got %0d expected 0", msi_vector); end
    n_cmp++; if (pending !== '0)      begin n_bad++; $display("FAIL rst_pend: got %h expected 00", pending); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_terr: got %b expected 0", timeout_err); end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    exp_q.push_back(5'd3);
    pulse_irq(8'h08);
    n_cmp++; if (pending !== 8'h08 || msi_req !== 1'b0) begin n_bad++; $display("FAIL single_capture: got pend %h req %b expected 08 0", pending, msi_req); end
    wait_req(10, n);
    n_cmp++; if (n != 1) begin n_bad++; $display("FAIL single_latency: got %0d expected 1", n); end
    tick(4);
    grant_now();
    n_cmp++; if (msi_req !== 1'b0 || pending[3] !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL single_grant: got req %b pend %h busy %b expected 0 00 1", msi_req, pending, busy); end
    tick(2);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(5'd0); exp_q.push_back(5'd1); exp_q.push_back(5'd3);
      pulse_irq(8'h0B);
      for (int j = 0; j < 3; j++) begin
        wait_req(20, n);
        tick(2);
        grant_now();
      end
      tick(2);
      n_cmp++; if (pending !== '0 || busy !== 1'b0) begin n_bad++; $display("FAIL rr_done: got pend %h busy %b expected 00 0", pending, busy); end
      tick(300);
    end
  endtask

  task automatic test_holdoff();
    int n, t0;
    do_reset();
    exp_q.push_back(5'd2);
    pulse_irq(8'h04);
    wait_req(10, n);
    t0 = cyc + 1;
    grant_now();
    for (int j = 0; j < 5; j++) begin
      tick(15);
      pulse_irq(8'h04);
    end
    n_cmp++; if (pending !== 8'h04 || busy !== 1'b0) begin n_bad++; $display("FAIL hold_coalesce: got pend %h busy %b expected 04 0", pending, busy); end
    exp_q.push_back(5'd2);
    wait_req(400, n);
    n_cmp++; if (cyc - t0 < 256 || cyc - t0 > 260) begin n_bad++; $display("FAIL hold_gap: got %0d expected 256..260", cyc - t0); end
    grant_now();
    tick(300);
    n_cmp++; if (pending !== '0 || busy !== 1'b0) begin n_bad++; $display("FAIL hold_single: got pend %h busy %b expected 00 0", pending, busy); end
  endtask

  task automatic test_fail_retry();
    int n, c;
    do_reset();
    exp_q.push_back(5'd5); exp_q.push_back(5'd5);
    pulse_irq(8'h20);
    wait_req(10, n);
    msi_fail = 1'b1;
    tick();
    msi_fail = 1'b0;
    n_cmp++; if (pending[5] !== 1'b1 || msi_req !== 1'b0) begin n_bad++; $display("FAIL fail_keep: got pend %h req %b expected 20 0", pending, msi_req); end
    c = 0;
    while (!msi_req && c < 100) begin c++; tick(); end
    n_cmp++; if (c != 17) begin n_bad++; $display("FAIL fail_low: got %0d expected 17", c); end
    grant_now();
    n_cmp++; if (pending[5] !== 1'b0) begin n_bad++; $display("FAIL fail_clear: got %b expected 0", pending[5]); end
    tick(2);
  endtask

  task automatic test_timeout();
    int n, c, e;
    do_reset();
    exp_q.push_back(5'd6); exp_q.push_back(5'd6);
    pulse_irq(8'h40);
    wait_req(10, n);
    c = 0; e = 0;
    while (msi_req && c < 200) begin
      if (timeout_err) e++;
      c++;
      tick();
    end
    n_cmp++; if (c != 64 || e != 0) begin n_bad++; $display("FAIL tmo_high: got %0d cycles %0d early pulses expected 64 0", c, e); end
    n_cmp++; if (timeout_err !== 1'b1 || pending[6] !== 1'b1) begin n_bad++; $display("FAIL tmo_pulse: got terr %b pend %h expected 1 40", timeout_err, pending); end
    tick();
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_width: got %b expected 0", timeout_err); end
    c = 1;
    while (!msi_req && c < 100) begin c++; tick(); end
    n_cmp++; if (c != 17) begin n_bad++; $display("FAIL tmo_retry: got %0d expected 17", c); end
    grant_now();
    n_cmp++; if (pending !== '0) begin n_bad++; $display("FAIL tmo_clear: got %h expected 00", pending); end
    tick(2);
  endtask

  task automatic test_coincident();
    int n, t0;
    do_reset();
    exp_q.push_back(5'd1);
    pulse_irq(8'h02);
    wait_req(10, n);
    t0 = cyc + 1;
    irq_in = 8'h02;
    grant_now();
    irq_in = '0;
    n_cmp++; if (pending[1] !== 1'b1 || msi_req !== 1'b0) begin n_bad++; $display("FAIL coinc_keep: got pend %h req %b expected 02 0", pending, msi_req); end
    exp_q.push_back(5'd1);
    wait_req(400, n);
    n_cmp++; if (cyc - t0 < 256) begin n_bad++; $display("FAIL coinc_hold: got %0d expected >=256", cyc - t0); end
    grant_now();
    n_cmp++; if (pending !== '0) begin n_bad++; $display("FAIL coinc_clear: got %h expected 00", pending); end
    tick(2);
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    exp_q.push_back(5'd4);
    pulse_irq(8'h10);
    wait_req(10, n);
    reset = 1'b1;
    msi_grant = 1'b1;
    tick();
    n_cmp++; if (msi_req !== 1'b0 || pending !== '0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst: got req %b pend %h busy %b expected 0 00 0", msi_req, pending, busy); end
    reset = 1'b0;
    msi_grant = 1'b0;
    tick(3);
    n_cmp++; if (msi_req !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_after: got req %b busy %b expected 0 0", msi_req, busy); end
  endtask

  task automatic test_enable();
    int n;
    do_reset();
    src_enable = 8'h7F;
    pulse_irq(8'h80);
    tick(3);
    n_cmp++; if (pending !== '0 || busy !== 1'b0) begin n_bad++; $display("FAIL en_block: got pend %h busy %b expected 00 0", pending, busy); end
    src_enable = '1;
    exp_q.push_back(5'd7);
    irq_in = 8'h80;
    tick();
    irq_in = '0;
    src_enable = 8'h7F;
    tick(5);
    n_cmp++; if (pending !== 8'h80 || busy !== 1'b0) begin n_bad++; $display("FAIL en_hold: got pend %h busy %b expected 80 0", pending, busy); end
    src_enable = '1;
    wait_req(10, n);
    grant_now();
    tick(3);
  endtask

  initial begin
    fork monitor(); join_none
    test_reset();
    test_single();
    test_round_robin();
    test_holdoff();
    test_fail_retry();
    test_timeout();
    test_coincident();
    test_reset_mid();
    test_enable();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left: got %0d expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
